// File: rtl/uart_crc_pkg.sv
// Shared types and the bit-serial CRC-8 update used by the UART CRC receive controller.
package uart_crc_pkg;

   localparam logic [7:0] CRC8_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC8_INIT_DEFAULT = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      CHECK = 2'd2
   } state_t;

   // One MSB-first CRC-8 step; the x^8 term of the polynomial is implicit.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc,
                                            input logic       din,
                                            input logic [7:0] poly);
      logic fb;
      fb = crc[7] ^ din;
      return {crc[6:0], 1'b0} ^ (fb ? poly : 8'h00);
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered head entry and registered empty flag.
module sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic [CW-1:0]    count_next;
   logic             do_push;
   logic             do_pop;

   always_comb begin
      full       = (count == CW'(DEPTH));
      do_pop     = pop && !empty;
      do_push    = push && (!full || do_pop);
      rd_next    = rd_ptr + AW'(1);
      count_next = count;
      case ({do_push, do_pop})
         2'b10:   count_next = count + CW'(1);
         2'b01:   count_next = count - CW'(1);
         default: count_next = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Head register tracks the entry that will be at rd_ptr after this edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         empty  <= 1'b1;
         rdata  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_next;
         end
         count <= count_next;
         empty <= (count_next == CW'(0));
         if (do_push && (empty || (do_pop && count == CW'(1)))) begin
            rdata <= wdata;
         end else if (do_pop && count > CW'(1)) begin
            rdata <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/uart_crc_rx_ctrl.sv
// Receive sequencer: captures {data, crc} frames, re-checks CRC-8 bit-serially,
// queues good bytes and keeps saturating error/drop/overrun statistics.
module uart_crc_rx_ctrl
   import uart_crc_pkg::*;
#(
   parameter logic [7:0]  POLY       = CRC8_POLY_DEFAULT,
   parameter logic [7:0]  CRC_INIT   = CRC8_INIT_DEFAULT,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [7:0]       rx_data,
   input  logic [7:0]       rx_crc,
   input  logic             rx_ready,
   output logic [7:0]       out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             crc_err,
   output logic             busy,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] drop_cnt,
   output logic [CNT_W-1:0] ovr_cnt,
   input  logic             clear_stats
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t          state;
   logic            rx_ready_d;
   logic            armed;
   logic [7:0]      data_q;
   logic [7:0]      crc_rx_q;
   logic [7:0]      crc_reg;
   logic [2:0]      idx;
   logic            push_q;

   logic            fifo_full;
   logic            fifo_empty;
   logic [CW-1:0]   fifo_count;

   logic            frame_evt_c;
   logic            crc_match_c;
   logic            pop_c;
   logic            space_c;
   logic            push_c;
   logic            err_inc_c;
   logic            drop_inc_c;
   logic            ovr_inc_c;

   // armed masks the first cycle after reset so a held rx_ready is not an edge.
   always_comb begin
      frame_evt_c = rx_ready && !rx_ready_d && armed;
      crc_match_c = (crc_reg == crc_rx_q);
      pop_c       = out_ready && !fifo_empty;
      space_c     = (fifo_count != CW'(FIFO_DEPTH)) || pop_c;
      push_c      = push_q && (!fifo_full || pop_c);
      err_inc_c   = (state == CHECK) && !crc_match_c;
      drop_inc_c  = (state == CHECK) && crc_match_c && !space_c;
      ovr_inc_c   = frame_evt_c && (state != IDLE);
   end

   assign out_valid = !fifo_empty;

   // Sequencer; the push decided in CHECK lands in the FIFO one edge later.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         rx_ready_d <= 1'b0;
         armed      <= 1'b0;
         data_q     <= '0;
         crc_rx_q   <= '0;
         crc_reg    <= '0;
         idx        <= '0;
         push_q     <= 1'b0;
         crc_err    <= 1'b0;
         busy       <= 1'b0;
      end else begin
         rx_ready_d <= rx_ready;
         armed      <= 1'b1;
         push_q     <= 1'b0;
         crc_err    <= 1'b0;
         case (state)
            IDLE: begin
               if (frame_evt_c) begin
                  data_q   <= rx_data;
                  crc_rx_q <= rx_crc;
                  crc_reg  <= CRC_INIT;
                  idx      <= 3'd7;
                  busy     <= 1'b1;
                  state    <= CALC;
               end
            end
            CALC: begin
               crc_reg <= crc8_step(crc_reg, data_q[idx], POLY);
               idx     <= idx - 3'd1;
               if (idx == 3'd0) begin
                  state <= CHECK;
               end
            end
            CHECK: begin
               busy  <= 1'b0;
               state <= IDLE;
               if (crc_match_c) begin
                  push_q <= space_c;
               end else begin
                  crc_err <= 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Saturating statistics; clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (reset || clear_stats) begin
         err_cnt  <= '0;
         drop_cnt <= '0;
         ovr_cnt  <= '0;
      end else begin
         if (err_inc_c && err_cnt != CNT_MAX) begin
            err_cnt <= err_cnt + CNT_W'(1);
         end
         if (drop_inc_c && drop_cnt != CNT_MAX) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
         end
         if (ovr_inc_c && ovr_cnt != CNT_MAX) begin
            ovr_cnt <= ovr_cnt + CNT_W'(1);
         end
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_c),
      .wdata (data_q),
      .pop   (pop_c),
      .rdata (out_data),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

endmodule

// File: tb/tb_uart_crc_rx_ctrl.sv
// Directed bench for uart_crc_rx_ctrl with hand-computed CRC-8 (poly 0x07) vectors.
module tb_uart_crc_rx_ctrl;

   logic       clk;
   logic       reset;
   logic [7:0] rx_data;
   logic [7:0] rx_crc;
   logic       rx_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       crc_err;
   logic       busy;
   logic [7:0] err_cnt;
   logic [7:0] drop_cnt;
   logic [7:0] ovr_cnt;
   logic       clear_stats;

   int vectors;
   int miscompares;
   int err_pulses;
   logic [7:0] exp_order [4];

   uart_crc_rx_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .rx_data     (rx_data),
      .rx_crc      (rx_crc),
      .rx_ready    (rx_ready),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .crc_err     (crc_err),
      .busy        (busy),
      .err_cnt     (err_cnt),
      .drop_cnt    (drop_cnt),
      .ovr_cnt     (ovr_cnt),
      .clear_stats (clear_stats)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Advance n edges while counting crc_err pulses.
   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         tick();
         if (crc_err) err_pulses++;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One-cycle rx_ready pulse; returns just after the capture edge.
   task automatic frame(input logic [7:0] d, input logic [7:0] c);
      rx_data  = d;
      rx_crc   = c;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
   endtask

   task automatic pop_one();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      err_pulses  = 0;
      reset       = 1'b1;
      rx_ready    = 1'b0;
      rx_data     = 8'h00;
      rx_crc      = 8'h00;
      out_ready   = 1'b0;
      clear_stats = 1'b0;
      tick();
      tick();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data",  32'(out_data),  32'h00);
      check("rst_crc_err",   32'(crc_err),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_err_cnt",   32'(err_cnt),   32'd0);
      check("rst_drop_cnt",  32'(drop_cnt),  32'd0);
      check("rst_ovr_cnt",   32'(ovr_cnt),   32'd0);
      reset = 1'b0;
      tick();

      // Good frame, rx_ready held for three cycles
      rx_data  = 8'h01;
      rx_crc   = 8'h07;
      rx_ready = 1'b1;
      tick();
      check("good_busy", 32'(busy), 32'd1);
      watch(2);
      rx_ready = 1'b0;
      watch(6);
      watch(1);
      check("good_valid_k9",  32'(out_valid), 32'd0);
      check("good_busy_done", 32'(busy),      32'd0);
      watch(1);
      check("good_valid_k10", 32'(out_valid), 32'd1);
      check("good_data",      32'(out_data),  32'h01);
      check("good_no_err",    32'(err_pulses), 32'd0);
      check("good_no_ovr",    32'(ovr_cnt),   32'd0);
      pop_one();
      check("good_single_push", 32'(out_valid), 32'd0);

      // Bad CRC then the correct one
      err_pulses = 0;
      frame(8'hFF, 8'h00);
      watch(8);
      check("bad_err_k8", 32'(crc_err), 32'd0);
      watch(1);
      check("bad_err_k9", 32'(crc_err), 32'd1);
      check("bad_err_cnt", 32'(err_cnt), 32'd1);
      watch(1);
      check("bad_err_k10", 32'(crc_err),    32'd0);
      check("bad_pulses",  32'(err_pulses), 32'd1);
      check("bad_empty",   32'(out_valid),  32'd0);
      frame(8'hFF, 8'hF3);
      watch(9);
      watch(1);
      check("ff_valid", 32'(out_valid), 32'd1);
      check("ff_data",  32'(out_data),  32'hFF);
      check("ff_err",   32'(err_cnt),   32'd1);
      pop_one();

      // FIFO full: fifth good byte dropped
      for (int i = 0; i < 5; i++) begin
         frame(8'h00, 8'h00);
         watch(9);
      end
      check("full_drop_cnt", 32'(drop_cnt), 32'd1);
      check("full_err_cnt",  32'(err_cnt),  32'd1);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("full_pop_valid", 32'(out_valid), 32'd1);
         check("full_pop_data",  32'(out_data),  32'h00);
         tick();
      end
      check("full_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Overrun: second edge four cycles after capture carries a bad pair
      err_pulses = 0;
      frame(8'h01, 8'h07);
      watch(3);
      rx_data  = 8'hFF;
      rx_crc   = 8'h00;
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      check("ovr_cnt",  32'(ovr_cnt), 32'd1);
      check("ovr_busy", 32'(busy),    32'd1);
      watch(5);
      watch(1);
      check("ovr_valid",  32'(out_valid),  32'd1);
      check("ovr_data",   32'(out_data),   32'h01);
      check("ovr_no_err", 32'(err_pulses), 32'd0);
      check("ovr_err_cnt", 32'(err_cnt),   32'd1);
      pop_one();

      // Ordering, plus a pop during CHECK freeing space for a full FIFO
      frame(8'h01, 8'h07); watch(9);
      frame(8'hFF, 8'hF3); watch(9);
      frame(8'h00, 8'h00); watch(9);
      frame(8'h01, 8'h07); watch(9);
      frame(8'hFF, 8'hF3);
      watch(8);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("chkpop_drop", 32'(drop_cnt), 32'd1);
      check("chkpop_head", 32'(out_data), 32'hFF);
      tick();
      exp_order[0] = 8'hFF;
      exp_order[1] = 8'h00;
      exp_order[2] = 8'h01;
      exp_order[3] = 8'hFF;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check("order_valid", 32'(out_valid), 32'd1);
         check("order_data",  32'(out_data),  32'(exp_order[i]));
         tick();
      end
      check("order_drained", 32'(out_valid), 32'd0);
      out_ready = 1'b0;

      // Saturation of err_cnt
      err_pulses = 0;
      for (int i = 0; i < 260; i++) begin
         frame(8'hFF, 8'h00);
         watch(9);
      end
      check("sat_err_cnt", 32'(err_cnt),    32'd255);
      check("sat_pulses",  32'(err_pulses), 32'd260);
      check("sat_empty",   32'(out_valid),  32'd0);

      // clear_stats in the same cycle as a CRC error
      frame(8'hFF, 8'h00);
      watch(8);
      clear_stats = 1'b1;
      tick();
      clear_stats = 1'b0;
      check("clr_crc_err",  32'(crc_err),  32'd1);
      check("clr_err_cnt",  32'(err_cnt),  32'd0);
      check("clr_drop_cnt", 32'(drop_cnt), 32'd0);
      check("clr_ovr_cnt",  32'(ovr_cnt),  32'd0);
      tick();
      frame(8'hFF, 8'h00);
      watch(9);
      check("clr_recount", 32'(err_cnt), 32'd1);

      // Reset mid-CALC with rx_ready held high across reset
      frame(8'h01, 8'h07);
      watch(3);
      reset    = 1'b1;
      rx_ready = 1'b1;
      tick();
      check("mid_rst_busy",     32'(busy),      32'd0);
      check("mid_rst_valid",    32'(out_valid), 32'd0);
      check("mid_rst_data",     32'(out_data),  32'h00);
      check("mid_rst_crc_err",  32'(crc_err),   32'd0);
      check("mid_rst_err_cnt",  32'(err_cnt),   32'd0);
      reset = 1'b0;
      tick();
      check("post_rst_no_evt1", 32'(busy), 32'd0);
      tick();
      check("post_rst_no_evt2", 32'(busy), 32'd0);
      watch(10);
      check("post_rst_no_push", 32'(out_valid), 32'd0);
      rx_ready = 1'b0;
      tick();
      frame(8'h01, 8'h07);
      watch(10);
      check("post_rst_valid",   32'(out_valid), 32'd1);
      check("post_rst_data",    32'(out_data),  32'h01);
      check("post_rst_err_cnt", 32'(err_cnt),   32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_crc_rx_ctrl.md
Name: uart_crc_rx_ctrl

Overview:
Sequencing controller placed behind the UART receiver.
- Captures each received {data, crc} pair on the receiver's ready flag.
- Recomputes CRC-8 over the data byte with a bit-serial engine and compares it with the received CRC.
- Queues good bytes in a small FIFO with a valid/ready output.
- Keeps saturating error, drop and overrun statistics for the host.

Parameters:
- POLY, 8'h07, CRC-8 generator polynomial; implicit x^8 term.
- CRC_INIT, 8'h00, CRC register seed for each frame.
- FIFO_DEPTH, 4, good-byte FIFO entries; must be a power of 2, at least 2.
- CNT_W, 8, width of each statistics counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- rx_data  in  8  data byte from receiver
- rx_crc  in  8  CRC byte from receiver
- rx_ready  in  1  receiver frame-ready flag; level, may stay high for several cycles
- out_data  out  8  head-of-FIFO byte
- out_valid  out  1  FIFO not empty
- out_ready  in  1  downstream accept; a pop occurs when out_valid && out_ready
- crc_err  out  1  one-cycle pulse on CRC mismatch
- busy  out  1  high in CALC/CHECK
- err_cnt  out  CNT_W  CRC mismatches, saturating
- drop_cnt  out  CNT_W  good bytes lost because the FIFO was full, saturating
- ovr_cnt  out  CNT_W  frames arriving while busy, saturating
- clear_stats  in  1  synchronous clear of all three counters

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE; FIFO empty; out_valid=0; out_data=0; crc_err=0; busy=0; all counters 0; rx_ready_d=0.
- Frame detection: a frame event is rx_ready && !rx_ready_d, where rx_ready_d is rx_ready registered once. A held-high rx_ready yields exactly one event.
- IDLE:
  - On an event at edge k: latch rx_data and rx_crc, load crc_reg=CRC_INIT, set bit index=7, go to CALC.
- CALC (8 cycles, edges k+1..k+8):
  - MSB first: fb = crc_reg[7] ^ data[idx]; crc_reg = {crc_reg[6:0],1'b0} ^ (fb ? POLY : 0).
  - Decrement idx each cycle; after idx=0 is processed, go to CHECK.
- CHECK (edge k+9):
  - If crc_reg == latched crc and the FIFO is not full: push the data byte.
  - If the match holds but the FIFO is full: drop the byte and increment drop_cnt.
  - On mismatch: pulse crc_err for one cycle, increment err_cnt, push nothing.
  - Return to IDLE.
- Latency: out_valid rises 10 clocks after the capture edge when the FIFO was empty. Back-to-back frames are accepted once the controller is back in IDLE.
- Overrun: an event in CALC or CHECK increments ovr_cnt. That frame is discarded and the in-progress frame is unaffected.
- FIFO:
  - Push and pop in the same cycle are both honoured, with count unchanged.
  - When full, a pop in the CHECK cycle frees space, so the push succeeds.
  - out_data is the registered head entry; it is held stable while out_valid && !out_ready.
  - Pointers wrap modulo FIFO_DEPTH; count has width clog2(FIFO_DEPTH)+1.
- Counters:
  - All counters saturate at 2^CNT_W-1.
  - clear_stats takes priority over a same-cycle increment (result 0).
- Reset mid-frame: returns to IDLE, flushes the FIFO and discards the partial CRC. A rx_ready still high after reset does not generate an event until it deasserts and reasserts, because rx_ready_d is reset to 0 only for one cycle and then tracks the input.
  - Rule: the event is suppressed during the first cycle after reset.

Decomposition:
- Package uart_crc_pkg holds:
  - CRC8_POLY_DEFAULT=8'h07 and CRC8_INIT_DEFAULT=8'h00.
  - The state enum IDLE/CALC/CHECK (2-bit encoding).
  - A crc8_step function implementing the one-bit update.
- Sub-module sync_fifo: parameterised width/depth, push/pop/full/empty/count. It is instantiated once for the good-byte queue.
- The CRC engine stays inline.

Test Plan:
- Good frame: rx_data=8'h01, rx_crc=8'h07, rx_ready held high 3 cycles -> exactly one push; out_valid 10 clocks after capture; out_data=8'h01; crc_err never asserted.
- Bad CRC: rx_data=8'hFF, rx_crc=8'h00 (expected 8'hF3) -> one-cycle crc_err; err_cnt=1; FIFO stays empty. Repeat with rx_crc=8'hF3 -> byte queued.
- FIFO full: out_ready=0; send 5 good frames with data 8'h00 (crc 8'h00) -> 4 queued, drop_cnt=1. Then raise out_ready -> bytes pop in order over 4 cycles.
- Overrun: second rx_ready rising edge 4 cycles after the first -> ovr_cnt=1; the first frame completes normally.
- Saturation and clear: CNT_W=8; 260 bad frames -> err_cnt=255. clear_stats in the same cycle as a CRC error -> err_cnt=0.
- Reset mid-CALC: assert reset at cycle k+4 -> no push; all outputs return to their reset values the next cycle; the next good frame (8'h01/8'h07) passes.
